// File: rtl/led_fb_wr_if.sv
// Host pixel-write bus into the LED frame-buffer controller.
// The host drives master; the controller accepts on wr_valid & wr_ready.
interface led_fb_wr_if #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 5,
    parameter int DATA_W   = 24
);
    logic                wr_valid;
    logic                wr_ready;
    logic [ROW_BITS-1:0] wr_row;
    logic [COL_BITS-1:0] wr_col;
    logic                wr_half;
    logic [DATA_W-1:0]   wr_data;

    modport master (output wr_valid, wr_row, wr_col, wr_half, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_row, wr_col, wr_half, wr_data, output wr_ready);
endinterface

// File: rtl/led_fb_controller.sv
// Write-port owner and swap scheduler for a double-buffered LED frame RAM (hi/lo panel halves).
// Define FB_SWAP_TIMEOUT_EN to abandon a swap the scanner never acknowledges within SWAP_TIMEOUT cycles.
module led_fb_controller #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 5,
    parameter int DATA_W   = 24
`ifdef FB_SWAP_TIMEOUT_EN
    , parameter int SWAP_TIMEOUT = 1048575
`endif
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    led_fb_wr_if.slave                       wr,
    input  logic                             clear_req_i,
    input  logic [DATA_W-1:0]                clear_color_i,
    output logic                             clear_done_o,
    input  logic                             swap_req_i,
    output logic                             swap_done_o,
    output logic                             swap_err_o,
    output logic                             busy_o,
    output logic                             selected_buffer_o,
    input  logic                             actual_buffer_i,
    input  logic                             frame_start_i,
    output logic                             ram_we_hi_o,
    output logic                             ram_we_lo_o,
    output logic [ROW_BITS+COL_BITS:0]       ram_wr_addr_o,
    output logic [DATA_W-1:0]                ram_wr_data_o
);
    localparam int CNT_W = ROW_BITS + COL_BITS;
    localparam int AW    = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_SWAP = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  color_q, color_d;
    logic               swap_pend_q, swap_pend_d;
    logic               sel_q, sel_d;
    logic               back_q, back_d;
    logic               fs_prev_q;
    logic               we_hi_q, we_hi_d, we_lo_q, we_lo_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               clear_done_q, clear_done_d;
    logic               swap_done_q, swap_done_d;
    logic               swap_err_q, swap_err_d;
    logic               busy_q, busy_d;
    logic               wr_fire_s, clear_last_s, swap_ok_s, timeout_s;

    assign wr.wr_ready  = (state_q == S_IDLE) & ~swap_pend_q & ~rst_i;
    assign wr_fire_s    = wr.wr_valid & wr.wr_ready;
    assign clear_last_s = (state_q == S_CLEAR) & (cnt_q == {CNT_W{1'b1}});
    // Only a fresh frame on the newly requested buffer completes the swap.
    assign swap_ok_s    = (state_q == S_SWAP) & frame_start_i & ~fs_prev_q & (actual_buffer_i == sel_q);

`ifdef FB_SWAP_TIMEOUT_EN
    logic [20:0] tmo_q;

    // Cycles spent waiting for the scanner in the current swap.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != S_SWAP) begin
            tmo_q <= 21'd0;
        end else begin
            tmo_q <= tmo_q + 21'd1;
        end
    end

    assign timeout_s = (state_q == S_SWAP) & ~swap_ok_s & (tmo_q == 21'(SWAP_TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req_i) begin
                    state_d = S_CLEAR;
                end else if (swap_req_i) begin
                    state_d = S_SWAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (clear_last_s) begin
                    state_d = (swap_pend_q | swap_req_i) ? S_SWAP : S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_SWAP: begin
                if (swap_ok_s || timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SWAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values for the current state.
    always_comb begin
        cnt_d        = cnt_q;
        color_d      = color_q;
        swap_pend_d  = swap_pend_q;
        sel_d        = sel_q;
        back_d       = back_q;
        we_hi_d      = 1'b0;
        we_lo_d      = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        clear_done_d = 1'b0;
        swap_done_d  = 1'b0;
        swap_err_d   = 1'b0;
        if (wr_fire_s) begin
            we_hi_d = ~wr.wr_half;
            we_lo_d = wr.wr_half;
            addr_d  = {back_q, wr.wr_row, wr.wr_col};
            data_d  = wr.wr_data;
        end else begin
            addr_d  = addr_q;
        end
        case (state_q)
            S_IDLE: begin
                if (clear_req_i) begin
                    cnt_d       = {CNT_W{1'b0}};
                    color_d     = clear_color_i;
                    swap_pend_d = swap_req_i;
                end else if (swap_req_i) begin
                    sel_d = ~sel_q;
                end else begin
                    sel_d = sel_q;
                end
            end
            S_CLEAR: begin
                we_hi_d = 1'b1;
                we_lo_d = 1'b1;
                addr_d  = {back_q, cnt_q};
                data_d  = color_q;
                cnt_d   = cnt_q + CNT_W'(1);
                if (swap_req_i) begin
                    swap_pend_d = 1'b1;
                end else begin
                    swap_pend_d = swap_pend_q;
                end
                if (clear_last_s) begin
                    clear_done_d = 1'b1;
                    sel_d        = (swap_pend_q | swap_req_i) ? ~sel_q : sel_q;
                end else begin
                    clear_done_d = 1'b0;
                end
            end
            S_SWAP: begin
                if (swap_ok_s) begin
                    swap_done_d = 1'b1;
                    swap_pend_d = 1'b0;
                    back_d      = ~sel_q;
                end else if (timeout_s) begin
                    swap_err_d  = 1'b1;
                    swap_pend_d = 1'b0;
                    sel_d       = ~sel_q;
                end else begin
                    swap_pend_d = swap_pend_q;
                end
            end
            default: begin
                swap_pend_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE) | swap_pend_d;
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= {CNT_W{1'b0}};
            color_q      <= {DATA_W{1'b0}};
            swap_pend_q  <= 1'b0;
            sel_q        <= 1'b0;
            back_q       <= 1'b1;
            fs_prev_q    <= 1'b0;
            we_hi_q      <= 1'b0;
            we_lo_q      <= 1'b0;
            addr_q       <= {AW{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            clear_done_q <= 1'b0;
            swap_done_q  <= 1'b0;
            swap_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            swap_pend_q  <= swap_pend_d;
            sel_q        <= sel_d;
            back_q       <= back_d;
            fs_prev_q    <= frame_start_i;
            we_hi_q      <= we_hi_d;
            we_lo_q      <= we_lo_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            clear_done_q <= clear_done_d;
            swap_done_q  <= swap_done_d;
            swap_err_q   <= swap_err_d;
            busy_q       <= busy_d;
        end
    end

    assign clear_done_o      = clear_done_q;
    assign swap_done_o       = swap_done_q;
    assign swap_err_o        = swap_err_q;
    assign busy_o            = busy_q;
    assign selected_buffer_o = sel_q;
    assign ram_we_hi_o       = we_hi_q;
    assign ram_we_lo_o       = we_lo_q;
    assign ram_wr_addr_o     = addr_q;
    assign ram_wr_data_o     = data_q;
endmodule

// File: tb/tb_led_fb_controller.sv
// Self-checking bench for led_fb_controller: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_led_fb_controller;
    localparam int RB = 4;
    localparam int CB = 5;
    localparam int DW = 24;
`ifdef FB_SWAP_TIMEOUT_EN
    localparam int TMO = 100;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic [DW-1:0] clear_color = 24'h0;
    logic          swap_req = 1'b0;
    logic          actual_buffer = 1'b0;
    logic          frame_start = 1'b0;
    logic          clear_done, swap_done, swap_err, busy, selected_buffer;
    logic          ram_we_hi, ram_we_lo;
    logic [9:0]    ram_wr_addr;
    logic [DW-1:0] ram_wr_data;

    led_fb_wr_if #(.ROW_BITS(RB), .COL_BITS(CB), .DATA_W(DW)) wr_bus ();

    led_fb_controller #(
        .ROW_BITS(RB), .COL_BITS(CB), .DATA_W(DW)
`ifdef FB_SWAP_TIMEOUT_EN
        , .SWAP_TIMEOUT(TMO)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst), .wr(wr_bus.slave),
        .clear_req_i(clear_req), .clear_color_i(clear_color), .clear_done_o(clear_done),
        .swap_req_i(swap_req), .swap_done_o(swap_done), .swap_err_o(swap_err), .busy_o(busy),
        .selected_buffer_o(selected_buffer), .actual_buffer_i(actual_buffer),
        .frame_start_i(frame_start), .ram_we_hi_o(ram_we_hi), .ram_we_lo_o(ram_we_lo),
        .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = accepting host writes, 1 = filling back buffer, 2 = waiting for scanner
    int         m_mode = 0;
    int         m_idx = 0;
    int         m_wait = 0;
    bit         m_queued = 0;
    bit         m_front = 0;
    bit         m_back = 1;
    bit         m_fs_prev = 0;
    logic [23:0] m_color = 0;
    logic       e_we_hi = 0, e_we_lo = 0, e_cdone = 0, e_sdone = 0, e_serr = 0, e_busy = 0;
    logic [9:0] e_addr = 0;
    logic [23:0] e_data = 0;
    bit         mdl_on = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_idx = 0; m_wait = 0; m_queued = 0; m_front = 0; m_back = 1;
            m_fs_prev = 0; m_color = 0;
            e_we_hi = 0; e_we_lo = 0; e_cdone = 0; e_sdone = 0; e_serr = 0; e_busy = 0;
            e_addr = 0; e_data = 0;
        end else begin
            e_we_hi = 0; e_we_lo = 0; e_cdone = 0; e_sdone = 0; e_serr = 0;
            if (wr_bus.wr_valid && m_mode == 0 && !m_queued) begin
                e_we_hi = !wr_bus.wr_half;
                e_we_lo = wr_bus.wr_half;
                e_addr  = 10'(m_back * 512 + int'(wr_bus.wr_row) * 32 + int'(wr_bus.wr_col));
                e_data  = wr_bus.wr_data;
            end
            if (m_mode == 0) begin
                if (clear_req) begin
                    m_mode = 1; m_idx = 0; m_color = clear_color; m_queued = swap_req;
                end else if (swap_req) begin
                    m_mode = 2; m_front = !m_front; m_wait = 0;
                end
            end else if (m_mode == 1) begin
                e_we_hi = 1; e_we_lo = 1;
                e_addr  = 10'(m_back * 512 + m_idx);
                e_data  = m_color;
                if (swap_req) m_queued = 1;
                if (m_idx == 511) begin
                    e_cdone = 1;
                    if (m_queued) begin m_mode = 2; m_front = !m_front; m_wait = 0; end
                    else m_mode = 0;
                end else m_idx++;
            end else begin
                if (frame_start && !m_fs_prev && actual_buffer == m_front) begin
                    e_sdone = 1; m_back = !m_front; m_queued = 0; m_mode = 0;
                end
`ifdef FB_SWAP_TIMEOUT_EN
                else if (m_wait == TMO - 1) begin
                    e_serr = 1; m_front = !m_front; m_queued = 0; m_mode = 0;
                end else m_wait++;
`endif
            end
            m_fs_prev = frame_start;
            e_busy = (m_mode != 0) || m_queued;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (mdl_on) begin
            chk("we_hi", 32'(ram_we_hi), 32'(e_we_hi));
            chk("we_lo", 32'(ram_we_lo), 32'(e_we_lo));
            chk("addr", 32'(ram_wr_addr), 32'(e_addr));
            chk("data", 32'(ram_wr_data), 32'(e_data));
            chk("clear_done", 32'(clear_done), 32'(e_cdone));
            chk("swap_done", 32'(swap_done), 32'(e_sdone));
            chk("swap_err", 32'(swap_err), 32'(e_serr));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("selected", 32'(selected_buffer), 32'(m_front));
            chk("wr_ready", 32'(wr_bus.wr_ready), 32'(!rst && m_mode == 0 && !m_queued));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int row, input int col, input bit half, input logic [23:0] d);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_row   = 4'(row);
        wr_bus.wr_col   = 5'(col);
        wr_bus.wr_half  = half;
        wr_bus.wr_data  = d;
        tick();
        wr_bus.wr_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int which, input int limit, output bit found, output int cycles);
        found = 0;
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((which == 0 && clear_done) || (which == 1 && swap_done) || (which == 2 && swap_err)) begin
                found = 1;
                cycles = i;
                break;
            end
        end
    endtask

    // Runs a clear already started; swap_req pulses on step swap_at (-1 for none).
    task automatic run_clear(input int swap_at, input logic [9:0] base, input string tag);
        int n = 0;
        bit done = 0;
        bit rdy_bad = 0;
        logic [9:0] first = 10'h0;
        logic [9:0] last = 10'h0;
        for (int i = 0; i < 600; i++) begin
            swap_req = (i == swap_at);
            tick();
            if (ram_we_hi && ram_we_lo) begin
                if (n == 0) first = ram_wr_addr;
                last = ram_wr_addr;
                n++;
            end
            if (clear_done) begin done = 1; break; end
            if (wr_bus.wr_ready) rdy_bad = 1;
        end
        swap_req = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_nwr"}, 32'(n), 32'd512);
        chk({tag, "_first"}, 32'(first), 32'(base));
        chk({tag, "_last"}, 32'(last), 32'(base + 10'h1FF));
        chk({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
    endtask

    initial begin
        bit found;
        int cyc;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_row   = 4'h0;
        wr_bus.wr_col   = 5'h0;
        wr_bus.wr_half  = 1'b0;
        wr_bus.wr_data  = 24'h0;
        tick(); tick(); tick();
        mdl_on = 1;
        chk("rst_we", 32'({ram_we_hi, ram_we_lo}), 32'd0);
        chk("rst_sel", 32'(selected_buffer), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(wr_bus.wr_ready), 32'd1);

        // 1: single pixel write into the lo half of back buffer 1
        write_px(3, 7, 1'b1, 24'h123456);
        chk("t1_we_lo", 32'(ram_we_lo), 32'd1);
        chk("t1_we_hi", 32'(ram_we_hi), 32'd0);
        chk("t1_addr", 32'(ram_wr_addr), 32'h267);
        chk("t1_data", 32'(ram_wr_data), 32'h123456);

        // 2: full clear of back buffer 1; color is latched at the request
        clear_color = 24'hFF0000;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        clear_color = 24'h00ABCD;
        run_clear(-1, 10'h200, "t2");
        chk("t2_data", 32'(ram_wr_data), 32'hFF0000);
        tick();
        chk("t2_done_pulse", 32'(clear_done), 32'd0);

        // 3: swap; an edge with the old actual_buffer must not complete it
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("t3_sel", 32'(selected_buffer), 32'd1);
        actual_buffer = 1'b0;
        frame_start = 1'b1;
        tick(); tick();
        frame_start = 1'b0;
        tick();
        chk("t3_still_busy", 32'(busy), 32'd1);
        actual_buffer = 1'b1;
        tick();
        frame_start = 1'b1;
        wait_pulse(1, 10, found, cyc);
        chk("t3_swap_done", 32'(found), 32'd1);
        frame_start = 1'b0;
        write_px(1, 2, 1'b0, 24'hA5A5A5);
        chk("t3_addr_back0", 32'(ram_wr_addr), 32'h022);
        chk("t3_we_hi", 32'(ram_we_hi), 32'd1);

        // 4: swap requested on clear step 10 waits for the whole clear
        clear_color = 24'h0000FF;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run_clear(10, 10'h000, "t4");
        chk("t4_sel", 32'(selected_buffer), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("t4_old_edge_ignored", 32'(busy), 32'd1);
        actual_buffer = 1'b0;
        frame_start = 1'b1;
        wait_pulse(1, 10, found, cyc);
        chk("t4_swap_done", 32'(found), 32'd1);
        frame_start = 1'b0;
        tick();

`ifdef FB_SWAP_TIMEOUT_EN
        // 5: no frame_start -> timeout reverts the request
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        wait_pulse(2, 200, found, cyc);
        chk("t5_err", 32'(found), 32'd1);
        chk("t5_cycles", 32'(cyc), 32'd100);
        chk("t5_sel", 32'(selected_buffer), 32'd0);
        chk("t5_ready", 32'(wr_bus.wr_ready), 32'd1);
        tick();
`endif

        // make buffer 1 the front so reset has something to undo
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        actual_buffer = 1'b1;
        frame_start = 1'b1;
        wait_pulse(1, 10, found, cyc);
        chk("t6_pre_swap", 32'(found), 32'd1);
        frame_start = 1'b0;
        tick();

        // 6: clear+swap in one cycle (clear wins), reset at clear step 200
        clear_color = 24'h00FF00;
        clear_req = 1'b1;
        swap_req = 1'b1;
        tick();
        clear_req = 1'b0;
        swap_req = 1'b0;
        chk("t6_sel_held", 32'(selected_buffer), 32'd1);
        repeat (200) tick();
        chk("t6_mid_addr", 32'(ram_wr_addr), 32'h0C7);
        rst = 1'b1;
        actual_buffer = 1'b0;
        tick();
        chk("t6_we", 32'({ram_we_hi, ram_we_lo}), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_sel", 32'(selected_buffer), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_ready", 32'(wr_bus.wr_ready), 32'd1);
        write_px(15, 31, 1'b0, 24'hC0FFEE);
        chk("t6_we_hi", 32'(ram_we_hi), 32'd1);
        chk("t6_addr", 32'(ram_wr_addr), 32'h3FF);
        chk("t6_data", 32'(ram_wr_data), 32'hC0FFEE);
        tick(); tick();

        mdl_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
